// File: rtl/delay_align_pkg.sv
// delay_align_pkg
//   Shared definitions for the delay/alignment blocks.
//   - SAMPLE_W / sample_t : signed sample width and type shared with the
//     fixed delay lines.
//   - skew_state_t        : states of the skew measurement FSM.
package delay_align_pkg;

    localparam int SAMPLE_W = 25;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } skew_state_t;

endpackage

// File: rtl/delay_align_if.sv
// delay_align_if
//   Sample/strobe bundle between the early path, the late path and the
//   aligner.
//   Handshake: there is no ready. in_valid pushes data_in on the rising
//   edge; late_valid requests a pop on the rising edge; out_valid marks
//   data_out as new for exactly the one cycle after an accepted pop.
//   Signals:
//     data_in    early-path sample (signed)
//     in_valid   push strobe
//     late_valid pop request from the late path
//     data_out   aligned sample (signed, registered)
//     out_valid  data_out is new this cycle (registered)
//   Modports: master = stream source/sink, slave = the aligner.
interface delay_align_if #(
    parameter int WIDTH = 25
);
    logic signed [WIDTH-1:0] data_in;
    logic                    in_valid;
    logic                    late_valid;
    logic signed [WIDTH-1:0] data_out;
    logic                    out_valid;

    modport master (
        output data_in,
        output in_valid,
        output late_valid,
        input  data_out,
        input  out_valid
    );

    modport slave (
        input  data_in,
        input  in_valid,
        input  late_valid,
        output data_out,
        output out_valid
    );
endinterface

// File: rtl/delay_align_ram.sv
// delay_align_ram
//   DEPTH x WIDTH register array, one write port and one registered read
//   port. A read and a write to the same address in one cycle return the
//   old contents (needed when the buffer is full and pushes/pops at once).
//   Ports:
//     clk, reset (async, active-low), clear (sync): reset/flush the read
//       register only; array contents are not cleared.
//     wr_en, wr_addr, wr_data : write port
//     rd_en, rd_addr, rd_data : registered read port; rd_data holds when
//       rd_en is low.
module delay_align_ram #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic signed [WIDTH-1:0] rd_data
);

    logic signed [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (clear) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/delay_align.sv
// delay_align
//   Receive-side aligner. Early-path samples are captured into a circular
//   buffer and released one per late-path valid, re-aligning a bypass
//   stream with a pipeline of unknown latency. The distance from the first
//   push to the first pop request is measured once after reset/clear.
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous active-low reset
//     clear        synchronous flush (buffer, flags, FSM); beats push/pop
//     bus          delay_align_if slave: data_in/in_valid (push),
//                  late_valid (pop request), data_out/out_valid
//     level        occupancy 0..DEPTH
//     skew         skew counter / measured skew
//     skew_locked  measurement complete
//     overflow     sticky: push dropped while full
//     underflow    sticky: pop requested while empty
//     state        skew FSM state (debug)
module delay_align
    import delay_align_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    delay_align_if.slave      bus,
    output logic [CNT_W-1:0]  level,
    output logic [CNT_W-1:0]  skew,
    output logic              skew_locked,
    output logic              overflow,
    output logic              underflow,
    output skew_state_t       state
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_acc;
    logic             push_acc;
    logic             pop_rej;
    logic             out_valid_q;
    logic signed [WIDTH-1:0] rd_data;

    skew_state_t      state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    // A pop needs an entry already present: no same-cycle bypass from the
    // push. A push into a full buffer is allowed only when a pop frees the
    // slot in the same cycle.
    assign pop_acc  = bus.late_valid && (level != '0);
    assign pop_rej  = bus.late_valid && (level == '0);
    assign push_acc = bus.in_valid && ((level != FULL_LVL) || pop_acc);

    delay_align_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (push_acc && !clear),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (pop_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign bus.data_out  = rd_data;
    assign bus.out_valid = out_valid_q;

    // Pointers, level, output strobe and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_valid_q <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_valid_q <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            // DEPTH is a power of 2, so natural pointer wrap is modulo DEPTH.
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
            out_valid_q <= pop_acc;
            if (bus.in_valid && !push_acc) begin
                overflow <= 1'b1;
            end
            if (pop_rej) begin
                underflow <= 1'b1;
            end
        end
    end

    // Skew FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt_q <= '0;
        end else if (clear) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Skew FSM: next state. The counter holds the cycles elapsed since the
    // first accepted push and freezes at the first pop request.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (push_acc) begin
                    if (bus.late_valid) begin
                        state_nxt = LOCKED;
                    end else begin
                        state_nxt = MEASURE;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            MEASURE: begin
                if (bus.late_valid) begin
                    state_nxt = LOCKED;
                end else if (cnt_q != '1) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                state_nxt = LOCKED;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign skew        = cnt_q;
    assign skew_locked = (state == LOCKED);

endmodule
